// File: rtl/frame_rx_deframer_pkg.sv
// frame_rx_pkg: shared constants for the receive deframer.
//   - FSM state encoding (IDLE/PRE/DATA/DROP)
//   - PRE_BYTE / SFD_BYTE framing markers
//   - CNT_W: width of the good/bad frame counters
package frame_rx_pkg;

    localparam int CNT_W = 16;

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

endpackage

// File: rtl/frame_rx_deframer_if.sv
// frame_rx_if: byte stream into the deframer and payload stream out of it.
//   rxd/rx_dv               : incoming bytes and frame envelope
//   dout/dout_vld           : payload byte and its valid (no backpressure)
//   dout_sof/dout_eof       : first / last payload byte markers
// master = upstream source / downstream sink side, slave = the deframer.
interface frame_rx_if;

    logic [7:0] rxd;
    logic       rx_dv;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_sof;
    logic       dout_eof;

    modport master (
        output rxd, rx_dv,
        input  dout, dout_vld, dout_sof, dout_eof
    );

    modport slave (
        input  rxd, rx_dv,
        output dout, dout_vld, dout_sof, dout_eof
    );

endinterface

// File: rtl/frame_rx_deframer_sat_cnt.sv
// sat_cnt16: saturating up-counter used for the good/bad frame statistics.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one this cycle (ignored once the count is all ones)
//   count      : current value
module sat_cnt16
    import frame_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_rx_deframer.sv
// frame_rx_deframer: strips preamble/SFD from the rxd/rx_dv stream, forwards
// payload with sof/eof markers, checks length and 8-bit additive checksum and
// keeps saturating good/bad frame counters.
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus (slave)           : rxd/rx_dv in, dout/dout_vld/dout_sof/dout_eof out
//   frame_done            : one-cycle end-of-frame status strobe
//   frame_len             : payload length (checksum byte included)
//   len_err, chk_err      : status flags, valid with frame_done
//   good_cnt, bad_cnt     : saturating frame counters
module frame_rx_deframer
    import frame_rx_pkg::*;
#(
    parameter int MIN_LEN = 4,
    parameter int MAX_LEN = 1518,
    parameter int MAX_PRE = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    frame_rx_if.slave        bus,
    output logic             frame_done,
    output logic [15:0]      frame_len,
    output logic             len_err,
    output logic             chk_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [7:0]  PRE_LIM = 8'(MAX_PRE);
    localparam logic [15:0] LEN_MIN = 16'(MIN_LEN);
    localparam logic [15:0] LEN_MAX = 16'(MAX_LEN);

    state_t      state, state_nxt;
    logic [7:0]  pre_cnt, pre_nxt;
    logic [15:0] len, len_nxt;
    logic [7:0]  sum, sum_nxt;
    logic [7:0]  hold, hold_nxt;

    logic [7:0]  dout_nxt;
    logic        vld_nxt, sof_nxt, eof_nxt, done_nxt, lerr_nxt, cerr_nxt;
    logic [15:0] flen_nxt;
    logic        good_inc, bad_inc;

    // The hold register is full exactly when len is non-zero, so the byte
    // leaving hold is the first payload byte precisely when len==1.
    always_comb begin
        state_nxt = state;
        pre_nxt   = pre_cnt;
        len_nxt   = len;
        sum_nxt   = sum;
        hold_nxt  = hold;
        dout_nxt  = 8'h00;
        vld_nxt   = 1'b0;
        sof_nxt   = 1'b0;
        eof_nxt   = 1'b0;
        done_nxt  = 1'b0;
        flen_nxt  = 16'h0000;
        lerr_nxt  = 1'b0;
        cerr_nxt  = 1'b0;
        good_inc  = 1'b0;
        bad_inc   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.rx_dv) begin
                    if (bus.rxd == PRE_BYTE) begin
                        state_nxt = ST_PRE;
                        pre_nxt   = 8'd1;
                    end else if (bus.rxd == SFD_BYTE) begin
                        state_nxt = ST_DATA;
                        len_nxt   = 16'h0000;
                        sum_nxt   = 8'h00;
                    end else begin
                        state_nxt = ST_DROP;
                        bad_inc   = 1'b1;
                    end
                end
            end

            ST_PRE: begin
                if (!bus.rx_dv) begin
                    state_nxt = ST_IDLE;
                    bad_inc   = 1'b1;
                end else if ((bus.rxd == PRE_BYTE) && (pre_cnt < PRE_LIM)) begin
                    pre_nxt = pre_cnt + 8'd1;
                end else if (bus.rxd == SFD_BYTE) begin
                    state_nxt = ST_DATA;
                    len_nxt   = 16'h0000;
                    sum_nxt   = 8'h00;
                end else begin
                    state_nxt = ST_DROP;
                    bad_inc   = 1'b1;
                end
            end

            ST_DATA: begin
                if (bus.rx_dv && (len == LEN_MAX)) begin
                    // Byte MAX_LEN+1: close the frame on the held byte and
                    // discard the rest of the envelope.
                    dout_nxt  = hold;
                    vld_nxt   = 1'b1;
                    sof_nxt   = (len == 16'd1);
                    eof_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    flen_nxt  = len;
                    lerr_nxt  = 1'b1;
                    bad_inc   = 1'b1;
                    state_nxt = ST_DROP;
                end else if (bus.rx_dv) begin
                    len_nxt  = len + 16'd1;
                    sum_nxt  = sum + bus.rxd;
                    hold_nxt = bus.rxd;
                    if (len != 16'h0000) begin
                        dout_nxt = hold;
                        vld_nxt  = 1'b1;
                        sof_nxt  = (len == 16'd1);
                    end
                end else begin
                    done_nxt = 1'b1;
                    flen_nxt = len;
                    lerr_nxt = (len < LEN_MIN);
                    cerr_nxt = (sum != 8'h00);
                    if (len != 16'h0000) begin
                        dout_nxt = hold;
                        vld_nxt  = 1'b1;
                        sof_nxt  = (len == 16'd1);
                        eof_nxt  = 1'b1;
                    end
                    if ((len < LEN_MIN) || (sum != 8'h00)) begin
                        bad_inc = 1'b1;
                    end else begin
                        good_inc = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
            end

            ST_DROP: begin
                if (!bus.rx_dv) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pre_cnt      <= 8'h00;
            len          <= 16'h0000;
            sum          <= 8'h00;
            hold         <= 8'h00;
            bus.dout     <= 8'h00;
            bus.dout_vld <= 1'b0;
            bus.dout_sof <= 1'b0;
            bus.dout_eof <= 1'b0;
            frame_done   <= 1'b0;
            frame_len    <= 16'h0000;
            len_err      <= 1'b0;
            chk_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            pre_cnt      <= pre_nxt;
            len          <= len_nxt;
            sum          <= sum_nxt;
            hold         <= hold_nxt;
            bus.dout     <= dout_nxt;
            bus.dout_vld <= vld_nxt;
            bus.dout_sof <= sof_nxt;
            bus.dout_eof <= eof_nxt;
            frame_done   <= done_nxt;
            frame_len    <= flen_nxt;
            len_err      <= lerr_nxt;
            chk_err      <= cerr_nxt;
        end
    end

    sat_cnt16 u_good_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (good_inc),
        .count (good_cnt)
    );

    sat_cnt16 u_bad_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bad_inc),
        .count (bad_cnt)
    );

endmodule

// File: tb/tb_frame_rx_deframer.sv
// tb_frame_rx_deframer: directed frames into frame_rx_deframer (MAX_LEN=8).
// A frame-level model turns each stimulus frame into the payload bytes and
// status record it must produce; a negedge process compares the DUT against
// those queues, and each scenario ends with hand-computed literal checks.
module tb_frame_rx_deframer;

    localparam int MIN_LEN = 4;
    localparam int MAX_LEN = 8;
    localparam int MAX_PRE = 7;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } exp_byte_t;

    typedef struct {
        logic [15:0] len;
        logic        len_err;
        logic        chk_err;
        logic        has_eof;
        logic [15:0] good;
        logic [15:0] bad;
    } exp_stat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_done;
    logic [15:0] frame_len;
    logic        len_err;
    logic        chk_err;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    frame_rx_if bus();

    frame_rx_deframer #(
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN),
        .MAX_PRE (MAX_PRE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .len_err    (len_err),
        .chk_err    (chk_err),
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
    );

    always #5 clk = ~clk;

    exp_byte_t   exp_bytes[$];
    exp_stat_t   exp_stats[$];
    int          checks = 0;
    int          errors = 0;
    int          good_m = 0;
    int          bad_m = 0;
    int          vld_seen = 0;
    int          done_seen = 0;
    logic [15:0] last_len = 16'h0;
    logic        last_chk = 1'b0;
    logic        last_lerr = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void bumpGood();
        if (good_m < 65535) good_m++;
    endfunction

    function automatic void bumpBad();
        if (bad_m < 65535) bad_m++;
    endfunction

    // Frame-level model: preamble/SFD parse, then payload bytes and status.
    // An aborted frame is cut by reset right after its last byte is sampled,
    // so only the bytes that already left the one-byte delay are expected.
    function automatic void modelFrame(input byte_q_t f, input bit abort);
        int         i = 0;
        int         pre = 0;
        int         n;
        logic [7:0] sum = 8'h00;
        exp_byte_t  e;
        exp_stat_t  s;
        while ((i < f.size()) && (f[i] == 8'h55)) begin
            pre++;
            i++;
            if (pre > MAX_PRE) begin
                bumpBad();
                return;
            end
        end
        if (i == f.size()) begin
            if (!abort && (pre > 0)) bumpBad();
            return;
        end
        if (f[i] != 8'hD5) begin
            bumpBad();
            return;
        end
        n = f.size() - i - 1;
        if (n > MAX_LEN) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                e.data = f[i+1+k];
                e.sof  = (k == 0);
                e.eof  = (k == MAX_LEN - 1);
                exp_bytes.push_back(e);
            end
            bumpBad();
            s.len = 16'(MAX_LEN); s.len_err = 1'b1; s.chk_err = 1'b0; s.has_eof = 1'b1;
            s.good = 16'(good_m); s.bad = 16'(bad_m);
            exp_stats.push_back(s);
            return;
        end
        if (abort) begin
            for (int k = 0; k < n - 1; k++) begin
                e.data = f[i+1+k];
                e.sof  = (k == 0);
                e.eof  = 1'b0;
                exp_bytes.push_back(e);
            end
            return;
        end
        for (int k = 0; k < n; k++) begin
            e.data = f[i+1+k];
            e.sof  = (k == 0);
            e.eof  = (k == n - 1);
            exp_bytes.push_back(e);
            sum = sum + f[i+1+k];
        end
        s.len     = 16'(n);
        s.len_err = (n < MIN_LEN);
        s.chk_err = (sum != 8'h00);
        s.has_eof = (n > 0);
        if (s.len_err || s.chk_err) bumpBad();
        else bumpGood();
        s.good = 16'(good_m);
        s.bad  = 16'(bad_m);
        exp_stats.push_back(s);
    endfunction

    // Drives one frame; 'gap' cycles of rx_dv=0 follow unless aborted.
    task automatic applyStimulus(input byte_q_t f, input int gap, input bit abort);
        modelFrame(f, abort);
        foreach (f[k]) begin
            @(posedge clk); #1;
            bus.rx_dv = 1'b1;
            bus.rxd   = f[k];
        end
        if (!abort) begin
            @(posedge clk); #1;
            bus.rx_dv = 1'b0;
            bus.rxd   = 8'h00;
            repeat (gap - 1) @(posedge clk);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic resetDut();
        rst_n     = 1'b0;
        bus.rx_dv = 1'b0;
        bus.rxd   = 8'h00;
        exp_bytes.delete();
        exp_stats.delete();
        good_m = 0;
        bad_m  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic endTest(input string name, input int good, input int bad);
        checkOutput({name, "_pending_bytes"}, 32'(exp_bytes.size()), 0);
        checkOutput({name, "_pending_status"}, 32'(exp_stats.size()), 0);
        checkOutput({name, "_good_cnt"}, 32'(good_cnt), 32'(good));
        checkOutput({name, "_bad_cnt"}, 32'(bad_cnt), 32'(bad));
    endtask

    always @(negedge clk) begin : compare
        exp_byte_t e;
        exp_stat_t s;
        if (bus.dout_vld) begin
            vld_seen++;
            if (exp_bytes.size() == 0) begin
                checkOutput("dout_vld_unexpected", 32'(bus.dout_vld), 0);
            end else begin
                e = exp_bytes.pop_front();
                checkOutput("dout", 32'(bus.dout), 32'(e.data));
                checkOutput("dout_sof", 32'(bus.dout_sof), 32'(e.sof));
                checkOutput("dout_eof", 32'(bus.dout_eof), 32'(e.eof));
            end
        end else begin
            checkOutput("marker_without_vld", 32'({bus.dout_sof, bus.dout_eof}), 0);
        end
        if (frame_done) begin
            done_seen++;
            last_len  = frame_len;
            last_chk  = chk_err;
            last_lerr = len_err;
            if (exp_stats.size() == 0) begin
                checkOutput("frame_done_unexpected", 32'(frame_done), 0);
            end else begin
                s = exp_stats.pop_front();
                checkOutput("frame_len", 32'(frame_len), 32'(s.len));
                checkOutput("len_err", 32'(len_err), 32'(s.len_err));
                checkOutput("chk_err", 32'(chk_err), 32'(s.chk_err));
                checkOutput("eof_with_done", 32'(bus.dout_eof), 32'(s.has_eof));
                checkOutput("good_cnt_at_done", 32'(good_cnt), 32'(s.good));
                checkOutput("bad_cnt_at_done", 32'(bad_cnt), 32'(s.bad));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        byte_q_t fr;
        int      v0;
        int      d0;

        bus.rx_dv = 1'b0;
        bus.rxd   = 8'h00;
        rst_n     = 1'b0;
        @(negedge clk); #1;
        checkOutput("reset_dout", 32'(bus.dout), 0);
        checkOutput("reset_strobes",
                    32'({bus.dout_vld, bus.dout_sof, bus.dout_eof, frame_done, len_err, chk_err}), 0);
        checkOutput("reset_frame_len", 32'(frame_len), 0);
        checkOutput("reset_counters", 32'({good_cnt, bad_cnt}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] good frame with full preamble");
        v0 = vld_seen; d0 = done_seen;
        fr = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
               8'h01, 8'h02, 8'h03, 8'hFA};
        applyStimulus(fr, 1, 1'b0);
        idleCycles(3);
        checkOutput("t1_bytes", 32'(vld_seen - v0), 4);
        checkOutput("t1_done", 32'(done_seen - d0), 1);
        checkOutput("t1_len", 32'(last_len), 4);
        checkOutput("t1_errs", 32'({last_lerr, last_chk}), 0);
        endTest("t1", 1, 0);

        $display("[TB] bad checksum");
        resetDut();
        v0 = vld_seen;
        fr = '{8'hD5, 8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(fr, 1, 1'b0);
        idleCycles(3);
        checkOutput("t2_bytes", 32'(vld_seen - v0), 4);
        checkOutput("t2_errs", 32'({last_lerr, last_chk}), 32'b01);
        endTest("t2", 0, 1);

        $display("[TB] preamble error then good frame");
        resetDut();
        v0 = vld_seen; d0 = done_seen;
        fr = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h02};
        applyStimulus(fr, 1, 1'b0);
        fr = '{8'hD5, 8'h01, 8'h02, 8'h03, 8'hFA};
        applyStimulus(fr, 1, 1'b0);
        idleCycles(3);
        checkOutput("t3_bytes", 32'(vld_seen - v0), 4);
        checkOutput("t3_done", 32'(done_seen - d0), 1);
        endTest("t3", 1, 1);

        $display("[TB] back-to-back frames, one-cycle gap");
        resetDut();
        v0 = vld_seen; d0 = done_seen;
        fr = '{8'h55, 8'hD5, 8'h10, 8'h20, 8'h30, 8'hA0};
        applyStimulus(fr, 1, 1'b0);
        fr = '{8'hD5, 8'hAA, 8'hBB, 8'hCC, 8'hCF};
        applyStimulus(fr, 1, 1'b0);
        idleCycles(3);
        checkOutput("t4_bytes", 32'(vld_seen - v0), 8);
        checkOutput("t4_done", 32'(done_seen - d0), 2);
        endTest("t4", 2, 0);

        $display("[TB] oversize frame");
        resetDut();
        v0 = vld_seen;
        fr = '{8'hD5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A};
        applyStimulus(fr, 1, 1'b0);
        idleCycles(3);
        checkOutput("t5_bytes", 32'(vld_seen - v0), 8);
        checkOutput("t5_len", 32'(last_len), 8);
        checkOutput("t5_errs", 32'({last_lerr, last_chk}), 32'b10);
        endTest("t5", 0, 1);

        $display("[TB] zero-length frame");
        resetDut();
        v0 = vld_seen; d0 = done_seen;
        fr = '{8'hD5};
        applyStimulus(fr, 1, 1'b0);
        idleCycles(3);
        checkOutput("t6_bytes", 32'(vld_seen - v0), 0);
        checkOutput("t6_done", 32'(done_seen - d0), 1);
        checkOutput("t6_len", 32'(last_len), 0);
        checkOutput("t6_errs", 32'({last_lerr, last_chk}), 32'b10);
        endTest("t6", 0, 1);

        $display("[TB] single-byte payload");
        resetDut();
        v0 = vld_seen;
        fr = '{8'hD5, 8'h00};
        applyStimulus(fr, 1, 1'b0);
        idleCycles(3);
        checkOutput("t7_bytes", 32'(vld_seen - v0), 1);
        checkOutput("t7_len", 32'(last_len), 1);
        endTest("t7", 0, 1);

        $display("[TB] preamble longer than allowed");
        resetDut();
        d0 = done_seen;
        fr = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
               8'h01, 8'h02, 8'h03, 8'hFA};
        applyStimulus(fr, 1, 1'b0);
        idleCycles(3);
        checkOutput("t8_done", 32'(done_seen - d0), 0);
        endTest("t8", 0, 1);

        $display("[TB] reset in the middle of a payload");
        v0 = vld_seen; d0 = done_seen;
        fr = '{8'hD5, 8'h01, 8'h02};
        applyStimulus(fr, 1, 1'b1);
        @(posedge clk);
        @(negedge clk); #1;
        rst_n     = 1'b0;
        bus.rx_dv = 1'b0;
        bus.rxd   = 8'h00;
        #1;
        checkOutput("t9_rst_strobes",
                    32'({bus.dout_vld, bus.dout_sof, bus.dout_eof, frame_done}), 0);
        checkOutput("t9_rst_dout", 32'(bus.dout), 0);
        checkOutput("t9_rst_counters", 32'({good_cnt, bad_cnt}), 0);
        checkOutput("t9_bytes_before_rst", 32'(vld_seen - v0), 1);
        checkOutput("t9_pending_before_rst", 32'(exp_bytes.size()), 0);
        good_m = 0;
        bad_m  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fr = '{8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'hFA};
        applyStimulus(fr, 1, 1'b0);
        idleCycles(3);
        checkOutput("t9_done", 32'(done_seen - d0), 1);
        checkOutput("t9_len", 32'(last_len), 4);
        endTest("t9", 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_rx_deframer.md
# frame_rx_deframer

Downstream byte-stream consumer of the registered receive stage. It takes the `rxd`/`rx_dv` pair that stage drives and removes the preamble and SFD. It forwards payload bytes with start/end markers, checks length and an 8-bit additive checksum, and keeps good/bad frame counters. A frame is one contiguous run of `rx_dv` high.

## Interface
- `MIN_LEN`, 4: minimum legal payload length in bytes, checksum byte included.
- `MAX_LEN`, 1518: maximum payload length; longer frames are truncated.
- `MAX_PRE`, 7: maximum number of 0x55 preamble bytes before the SFD.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rxd` in 8: incoming byte, from the upstream `txd`.
- `rx_dv` in 1: byte valid / frame envelope, from the upstream `tx_en`.
- `dout` out 8: payload byte.
- `dout_vld` out 1: `dout` valid; downstream always accepts.
- `dout_sof` out 1: marks the first payload byte.
- `dout_eof` out 1: marks the last payload byte.
- `frame_done` out 1: one-cycle status strobe.
- `frame_len` out 16: payload byte count, valid with `frame_done`.
- `len_err` out 1: length violation, valid with `frame_done`.
- `chk_err` out 1: checksum violation, valid with `frame_done`.
- `good_cnt` out 16: saturating count of frames with no error.
- `bad_cnt` out 16: saturating count of errored or dropped frames.

## Operation
- Inputs are sampled directly with no input register. All outputs are registered.
- States:
  - IDLE, PRE, DATA, DROP.
  - Encoding lives in the package.
- IDLE:
  - `rx_dv`=1 and byte 0x55 → PRE, with pre_cnt=1.
  - Byte 0xD5 → DATA.
  - Any other byte → DROP, and `bad_cnt`++.
- PRE:
  - 0x55 with pre_cnt<MAX_PRE → stay and increment pre_cnt.
  - 0xD5 → DATA, and clear len and sum.
  - Any other byte, or an extra 0x55 beyond MAX_PRE → DROP, and `bad_cnt`++.
  - `rx_dv`=0 → IDLE, and `bad_cnt`++.
- DATA uses a one-byte hold register:
  - Each sampled byte increments len, adds into the 8-bit sum, and moves into hold.
  - If hold was already full, the previous held byte is emitted first.
  - The first emitted byte of a frame carries `dout_sof`.
- End of frame (`rx_dv`=0 sampled in DATA):
  - The held byte is emitted with `dout_eof`=1 and `frame_done`=1.
  - `len_err` = (len<MIN_LEN). `chk_err` = (sum≠0).
  - Next state is IDLE.
- Single-byte payload: the byte carries both `dout_sof` and `dout_eof`.
- Zero-length frame (SFD followed immediately by `rx_dv`=0):
  - `frame_done`=1, `frame_len`=0, `len_err`=1, `chk_err`=0.
  - No `dout_vld`.
- Oversize: when byte MAX_LEN+1 is sampled in DATA:
  - The held byte (number MAX_LEN) is emitted with `dout_eof`.
  - `frame_done` fires with `frame_len`=MAX_LEN, `len_err`=1, `chk_err`=0.
  - Next state is DROP; byte MAX_LEN+1 and all later bytes are discarded.
- DROP: no outputs; `rx_dv`=0 → IDLE.
- Counters:
  - On `frame_done`: `good_cnt`++ if neither error flag is set, otherwise `bad_cnt`++.
  - Both counters saturate at 0xFFFF.
- Width rules: len is 16 bits; sum is modulo 256.

## Timing
- Reset (asynchronous): state=IDLE. All outputs 0: `dout`=0x00, all strobes 0, `frame_len`=0, both counters 0. Hold and len/sum registers are cleared.
- Latency: a payload byte sampled at edge E appears on `dout` after the edge at which the next byte, or `rx_dv`=0, is sampled. That is edge E+1 for contiguous input.
- `frame_done`, `frame_len`, `len_err` and `chk_err` are asserted in the same cycle as `dout_eof`.
- `dout_sof`, `dout_eof` and `frame_done` are single-cycle strobes.
- Minimum inter-frame gap is one cycle of `rx_dv`=0. The byte sampled on the following edge is handled by IDLE in the same cycle that the eof byte is on `dout`.
- Reset asserted mid-frame: the frame is abandoned with no strobe and no counter update.
- `rx_dv` already high when reset releases: handled by IDLE rules; a mid-payload byte normally leads to DROP.

## Structure
- Package `frame_rx_pkg`:
  - State encoding constants.
  - `PRE_BYTE`=8'h55 and `SFD_BYTE`=8'hD5.
  - Counter width 16.
- Sub-module `sat_cnt16`: 16-bit saturating incrementer with asynchronous active-low reset. Instantiated twice, for good and bad.
- Everything else stays in one module.

## Test plan
- Good frame: 7×55, D5, 01 02 03 FA, then `rx_dv`=0.
  - Expect `dout` 01 02 03 FA, `sof` on 01, `eof`+`frame_done` on FA.
  - `frame_len`=4, no errors, `good_cnt`=1.
- Bad checksum: D5, 01 02 03 04.
  - Expect 4 bytes out, `chk_err`=1, `len_err`=0, `bad_cnt`=1.
- Preamble error: 55 55 AA 01 02 with `rx_dv` high.
  - Expect no `dout_vld`, `bad_cnt`=1.
  - Then a good frame after one gap cycle is accepted, `good_cnt`=1.
- Back-to-back: two good frames separated by a one-cycle `rx_dv` low.
  - Expect two `frame_done` pulses, the second frame's `sof` byte intact, `good_cnt`=2.
- Oversize with MAX_LEN=8: D5 followed by 10 payload bytes.
  - Expect 8 bytes out with `eof` on the 8th, `frame_len`=8, `len_err`=1.
  - Bytes 9–10 are not output.
- Reset mid-DATA after 2 payload bytes:
  - All outputs go to 0 immediately, counters are 0, no `frame_done`.
  - The next clean frame is received correctly.
